// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: hex glyph table, blank byte,
// digit count and scan state encoding.
package seg_pkg;

  localparam int DIGITS = 8;

  localparam logic [7:0] SEG_OFF_AH = 8'h00;

  // Active-high {dp, g, f, e, d, c, b, a}, indexed by nibble value.
  localparam logic [15:0][7:0] SEG_LUT = {
    8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
    8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex-to-seven-segment decoder; active-high segment byte,
// forced to the blank byte when blank is set.
module hex_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg_ah
);

  always_comb begin
    seg_ah = SEG_OFF_AH;
    if (!blank) begin
      seg_ah = SEG_LUT[nibble] | {dp, 7'b0};
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit seven-segment scanner: tear-free shadow/pending display set,
// leading-zero suppression and a registered {sel, seg} word for the 74HC595 driver.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
  input  logic        clk_50mhz,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] disp_data,
  input  logic [7:0]  dp_mask,
  input  logic [7:0]  digit_en,
  input  logic        lz_en,
  input  logic        load,
  output logic [15:0] data,
  output logic        drv_en,
  output logic        frame_start
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [7:0]  SEL_OFF  = SEL_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [7:0]  SEG_OFF  = SEG_ACTIVE_LOW ? ~SEG_OFF_AH : SEG_OFF_AH;
  localparam logic [15:0] OFF_WORD = {SEL_OFF, SEG_OFF};

  scan_state_e      state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic [15:0]      data_q, data_d;
  logic             drv_en_q, drv_en_d;
  logic             frame_start_q, frame_start_d;
  logic             pend_q, pend_d;
  logic [31:0]      pnd_data_q, pnd_data_d, shd_data_q, shd_data_d;
  logic [7:0]       pnd_dp_q, pnd_dp_d, shd_dp_q, shd_dp_d;
  logic [7:0]       pnd_den_q, pnd_den_d, shd_den_q, shd_den_d;
  logic             pnd_lz_q, pnd_lz_d, shd_lz_q, shd_lz_d;

  logic [DIGITS-1:0] lz_blank;
  logic [3:0]        cur_nib;
  logic              cur_dp;
  logic              cur_blank;
  logic [7:0]        seg_ah;
  logic [7:0]        sel_ah;
  logic              scanning;
  logic              wrap;
  logic              commit_ok;

  // Suppression chain runs from the top digit down and stops at the first
  // non-zero nibble or lit decimal point; digit 0 always shows.
  always_comb begin
    lz_blank = '0;
    lz_blank[DIGITS-1] = shd_lz_q && (shd_data_q[31:28] == 4'h0) && !shd_dp_q[DIGITS-1];
    for (int i = DIGITS - 2; i >= 1; i--) begin
      lz_blank[i] = lz_blank[i+1] && (shd_data_q[i*4 +: 4] == 4'h0) && !shd_dp_q[i];
    end
  end

  always_comb begin
    cur_nib   = shd_data_q[{idx_q, 2'b00} +: 4];
    cur_dp    = shd_dp_q[idx_q];
    cur_blank = lz_blank[idx_q] || !shd_den_q[idx_q];
    sel_ah    = 8'h01 << idx_q;
  end

  hex_to_seg7 u_dec (
    .nibble (cur_nib),
    .dp     (cur_dp),
    .blank  (cur_blank),
    .seg_ah (seg_ah)
  );

  always_comb begin
    state_d       = state_q;
    div_d         = div_q;
    idx_d         = idx_q;
    data_d        = data_q;
    pend_d        = pend_q;
    pnd_data_d    = pnd_data_q;
    pnd_dp_d      = pnd_dp_q;
    pnd_den_d     = pnd_den_q;
    pnd_lz_d      = pnd_lz_q;
    shd_data_d    = shd_data_q;
    shd_dp_d      = shd_dp_q;
    shd_den_d     = shd_den_q;
    shd_lz_d      = shd_lz_q;

    scanning  = (state_q == SCAN) && en;
    wrap      = scanning && (div_q == DIV_LAST) && (idx_q == 3'd7);
    commit_ok = wrap || !en;

    state_d = en ? SCAN : IDLE;
    if (scanning) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        idx_d = idx_q + 3'd1;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end else begin
      div_d = '0;
      idx_d = '0;
    end

    // A load coinciding with a commit point bypasses the pending set entirely.
    if (load && commit_ok) begin
      shd_data_d = disp_data;
      shd_dp_d   = dp_mask;
      shd_den_d  = digit_en;
      shd_lz_d   = lz_en;
      pend_d     = 1'b0;
    end else if (load) begin
      pnd_data_d = disp_data;
      pnd_dp_d   = dp_mask;
      pnd_den_d  = digit_en;
      pnd_lz_d   = lz_en;
      pend_d     = 1'b1;
    end else if (pend_q && commit_ok) begin
      shd_data_d = pnd_data_q;
      shd_dp_d   = pnd_dp_q;
      shd_den_d  = pnd_den_q;
      shd_lz_d   = pnd_lz_q;
      pend_d     = 1'b0;
    end

    drv_en_d      = en;
    frame_start_d = scanning && (div_q == '0) && (idx_q == 3'd0);
    data_d        = OFF_WORD;
    if (scanning) begin
      data_d = {SEL_ACTIVE_LOW ? ~sel_ah : sel_ah, SEG_ACTIVE_LOW ? ~seg_ah : seg_ah};
    end
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      div_q         <= '0;
      idx_q         <= '0;
      data_q        <= OFF_WORD;
      drv_en_q      <= 1'b0;
      frame_start_q <= 1'b0;
      pend_q        <= 1'b0;
      pnd_data_q    <= '0;
      pnd_dp_q      <= '0;
      pnd_den_q     <= 8'hFF;
      pnd_lz_q      <= 1'b0;
      shd_data_q    <= '0;
      shd_dp_q      <= '0;
      shd_den_q     <= 8'hFF;
      shd_lz_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      idx_q         <= idx_d;
      data_q        <= data_d;
      drv_en_q      <= drv_en_d;
      frame_start_q <= frame_start_d;
      pend_q        <= pend_d;
      pnd_data_q    <= pnd_data_d;
      pnd_dp_q      <= pnd_dp_d;
      pnd_den_q     <= pnd_den_d;
      pnd_lz_q      <= pnd_lz_d;
      shd_data_q    <= shd_data_d;
      shd_dp_q      <= shd_dp_d;
      shd_den_q     <= shd_den_d;
      shd_lz_q      <= shd_lz_d;
    end
  end

  assign data        = data_q;
  assign drv_en      = drv_en_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl at SCAN_DIV=4: directed vector table, reset-in-flight
// sequence and randomized traffic against a cycle-count reference model.
module tb_seg_scan_ctrl;

  localparam int SD = 4;

  logic        clk_50mhz = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [31:0] disp_data = '0;
  logic [7:0]  dp_mask = '0;
  logic [7:0]  digit_en = 8'hFF;
  logic        lz_en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data;
  logic        drv_en;
  logic        frame_start;

  int vec_cnt = 0;
  int err_cnt = 0;

  seg_scan_ctrl #(.SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)) dut (
    .clk_50mhz   (clk_50mhz),
    .rst_n       (rst_n),
    .en          (en),
    .disp_data   (disp_data),
    .dp_mask     (dp_mask),
    .digit_en    (digit_en),
    .lz_en       (lz_en),
    .load        (load),
    .data        (data),
    .drv_en      (drv_en),
    .frame_start (frame_start)
  );

  always #5 clk_50mhz = ~clk_50mhz;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model: committed/pending display sets plus a count of edges
  // since scanning began; the digit shown is simply (count / SD) mod 8.
  logic        m_run, m_pend;
  int          m_p;
  logic [31:0] sh_data, pd_data;
  logic [7:0]  sh_dp, pd_dp, sh_den, pd_den;
  logic        sh_lz, pd_lz;
  logic [15:0] exp_data;
  logic        exp_fs, exp_drv;

  function automatic logic [7:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 8'h3F; 4'h1: glyph = 8'h06; 4'h2: glyph = 8'h5B; 4'h3: glyph = 8'h4F;
      4'h4: glyph = 8'h66; 4'h5: glyph = 8'h6D; 4'h6: glyph = 8'h7D; 4'h7: glyph = 8'h07;
      4'h8: glyph = 8'h7F; 4'h9: glyph = 8'h6F; 4'hA: glyph = 8'h77; 4'hB: glyph = 8'h7C;
      4'hC: glyph = 8'h39; 4'hD: glyph = 8'h5E; 4'hE: glyph = 8'h79; default: glyph = 8'h71;
    endcase
  endfunction

  function automatic logic [15:0] model_word(input int d);
    logic       supp, blk;
    logic [3:0] nib;
    logic [7:0] sel, seg;
    supp = sh_lz;
    blk  = 1'b0;
    nib  = '0;
    for (int k = 7; k >= d; k--) begin
      nib  = sh_data[k*4 +: 4];
      blk  = supp && (k != 0) && (nib == 4'h0) && !sh_dp[k];
      supp = blk;
    end
    sel = ~(8'h01 << d);
    if (blk || !sh_den[d]) seg = 8'hFF;
    else seg = ~(glyph(nib) | (sh_dp[d] ? 8'h80 : 8'h00));
    return {sel, seg};
  endfunction

  task automatic model_reset();
    m_run = 0; m_pend = 0; m_p = 0;
    sh_data = '0; sh_dp = '0; sh_den = 8'hFF; sh_lz = 0;
    pd_data = '0; pd_dp = '0; pd_den = 8'hFF; pd_lz = 0;
    exp_data = 16'hFFFF; exp_fs = 0; exp_drv = 0;
  endtask

  task automatic model_update();
    logic boundary;
    boundary = 1'b0;
    exp_drv  = en;
    if (m_run && en) begin
      exp_data = model_word((m_p / SD) % 8);
      exp_fs   = (m_p % (8 * SD)) == 0;
      boundary = (m_p % (8 * SD)) == (8 * SD - 1);
      m_p++;
    end else begin
      exp_data = 16'hFFFF;
      exp_fs   = 1'b0;
      m_p      = 0;
    end
    m_run = en;
    if (load && (boundary || !en)) begin
      sh_data = disp_data; sh_dp = dp_mask; sh_den = digit_en; sh_lz = lz_en; m_pend = 0;
    end else if (load) begin
      pd_data = disp_data; pd_dp = dp_mask; pd_den = digit_en; pd_lz = lz_en; m_pend = 1;
    end else if (m_pend && (boundary || !en)) begin
      sh_data = pd_data; sh_dp = pd_dp; sh_den = pd_den; sh_lz = pd_lz; m_pend = 0;
    end
  endtask

  task automatic check(input string name, input logic [15:0] d_exp, input logic fs_exp,
                       input logic drv_exp);
    vec_cnt++;
    if (data !== d_exp || frame_start !== fs_exp || drv_en !== drv_exp) begin
      err_cnt++;
      $display("FAIL %s @%0t: got data=%h fs=%b drv=%b, expected data=%h fs=%b drv=%b",
               name, $time, data, frame_start, drv_en, d_exp, fs_exp, drv_exp);
    end
  endtask

  // Called at a negedge; drives inputs, clocks once, checks against the model.
  task automatic step(input logic e, input logic ld, input logic [31:0] dd,
                      input logic [7:0] dm, input logic [7:0] de, input logic lz);
    en = e; load = ld; disp_data = dd; dp_mask = dm; digit_en = de; lz_en = lz;
    @(posedge clk_50mhz);
    model_update();
    @(negedge clk_50mhz);
    check("model", exp_data, exp_fs, exp_drv);
  endtask

  typedef struct {
    logic        en;
    logic        load;
    logic [31:0] disp;
    logic [7:0]  dpm;
    logic [7:0]  den;
    logic        lz;
    int          cyc;
    logic [15:0] exp_data;
    logic        exp_fs;
    logic        exp_drv;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic e, input logic ld, input logic [31:0] dd, input logic [7:0] dm,
                     input logic [7:0] de, input logic lz, input int cyc,
                     input logic [15:0] xd, input logic xfs);
    vec_t v;
    v.en = e; v.load = ld; v.disp = dd; v.dpm = dm; v.den = de; v.lz = lz;
    v.cyc = cyc; v.exp_data = xd; v.exp_fs = xfs; v.exp_drv = e;
    tbl.push_back(v);
  endtask

  initial begin
    // Blank after reset, then basic scan of 76543210.
    add(0, 1, 32'h76543210, 8'h00, 8'hFF, 0, 3,  16'hFFFF, 0);
    add(1, 0, 32'h76543210, 8'h00, 8'hFF, 0, 1,  16'hFFFF, 0);
    add(1, 0, 32'h76543210, 8'h00, 8'hFF, 0, 1,  16'hFEC0, 1);
    add(1, 0, 32'h76543210, 8'h00, 8'hFF, 0, 4,  16'hFDF9, 0);
    add(1, 0, 32'h76543210, 8'h00, 8'hFF, 0, 20, 16'hBF82, 0);
    add(1, 0, 32'h76543210, 8'h00, 8'hFF, 0, 4,  16'h7FF8, 0);
    add(1, 0, 32'h76543210, 8'h00, 8'hFF, 0, 4,  16'hFEC0, 1);
    // Load during digit 3: current frame keeps old digits, next frame shows F.
    add(1, 0, 32'h76543210, 8'h00, 8'hFF, 0, 12, 16'hF7B0, 0);
    add(1, 1, 32'hFFFFFFFF, 8'h00, 8'hFF, 0, 1,  16'hF7B0, 0);
    add(1, 0, 32'hFFFFFFFF, 8'h00, 8'hFF, 0, 3,  16'hEF99, 0);
    add(1, 0, 32'hFFFFFFFF, 8'h00, 8'hFF, 0, 12, 16'h7FF8, 0);
    add(1, 0, 32'hFFFFFFFF, 8'h00, 8'hFF, 0, 4,  16'hFE8E, 1);
    add(1, 0, 32'hFFFFFFFF, 8'h00, 8'hFF, 0, 8,  16'hFB8E, 0);
    // Disable during digit 5, load while disabled, re-enable.
    add(1, 0, 32'hFFFFFFFF, 8'h00, 8'hFF, 0, 12, 16'hDF8E, 0);
    add(0, 0, 32'hFFFFFFFF, 8'h00, 8'hFF, 0, 1,  16'hFFFF, 0);
    add(0, 1, 32'h00000500, 8'h00, 8'hFF, 1, 1,  16'hFFFF, 0);
    add(1, 0, 32'h00000500, 8'h00, 8'hFF, 1, 1,  16'hFFFF, 0);
    add(1, 0, 32'h00000500, 8'h00, 8'hFF, 1, 1,  16'hFEC0, 1);
    add(1, 0, 32'h00000500, 8'h00, 8'hFF, 1, 4,  16'hFDC0, 0);
    add(1, 0, 32'h00000500, 8'h00, 8'hFF, 1, 4,  16'hFB92, 0);
    add(1, 0, 32'h00000500, 8'h00, 8'hFF, 1, 4,  16'hF7FF, 0);
    add(1, 0, 32'h00000500, 8'h00, 8'hFF, 1, 4,  16'hEFFF, 0);
    add(1, 0, 32'h00000500, 8'h00, 8'hFF, 1, 12, 16'h7FFF, 0);
    // Decimal point on digit 4 halts suppression there.
    add(0, 1, 32'h00000500, 8'h10, 8'hFF, 1, 1,  16'hFFFF, 0);
    add(1, 0, 32'h00000500, 8'h10, 8'hFF, 1, 1,  16'hFFFF, 0);
    add(1, 0, 32'h00000500, 8'h10, 8'hFF, 1, 1,  16'hFEC0, 1);
    add(1, 0, 32'h00000500, 8'h10, 8'hFF, 1, 12, 16'hF7C0, 0);
    add(1, 0, 32'h00000500, 8'h10, 8'hFF, 1, 4,  16'hEF40, 0);
    add(1, 0, 32'h00000500, 8'h10, 8'hFF, 1, 4,  16'hDFFF, 0);
    // digit_en gating and a plain dp on digit 0.
    add(0, 1, 32'h76543210, 8'h00, 8'hFD, 0, 1,  16'hFFFF, 0);
    add(1, 0, 32'h76543210, 8'h00, 8'hFD, 0, 2,  16'hFEC0, 1);
    add(1, 0, 32'h76543210, 8'h00, 8'hFD, 0, 4,  16'hFDFF, 0);
    add(0, 1, 32'h76543210, 8'h01, 8'hFF, 0, 1,  16'hFFFF, 0);
    add(1, 0, 32'h76543210, 8'h01, 8'hFF, 0, 2,  16'hFE40, 1);

    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk_50mhz);
    #1;
    check("reset_state", 16'hFFFF, 1'b0, 1'b0);
    @(negedge clk_50mhz);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      for (int c = 0; c < tbl[i].cyc; c++) begin
        step(tbl[i].en, (c == 0) ? tbl[i].load : 1'b0, tbl[i].disp, tbl[i].dpm, tbl[i].den,
             tbl[i].lz);
      end
      check($sformatf("tbl[%0d]", i), tbl[i].exp_data, tbl[i].exp_fs, tbl[i].exp_drv);
    end

    // Reset during digit 6 with a pending load: output blanks at once and the
    // pending set must not survive.
    for (int c = 0; c < 24; c++) step(1, 0, 32'h0, 8'h01, 8'hFF, 0);
    check("digit6_before_reset", 16'hBF82, 1'b0, 1'b1);
    step(1, 1, 32'h12345678, 8'h00, 8'hFF, 0);
    rst_n = 1'b0;
    #1;
    check("async_reset", 16'hFFFF, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk_50mhz);
    @(negedge clk_50mhz);
    rst_n = 1'b1;
    step(1, 0, 32'h0, 8'h00, 8'hFF, 0);
    step(1, 0, 32'h0, 8'h00, 8'hFF, 0);
    check("post_reset_digit0", 16'hFEC0, 1'b1, 1'b1);
    for (int c = 0; c < 8; c++) step(1, 0, 32'h0, 8'h00, 8'hFF, 0);
    check("post_reset_digit2", 16'hFBC0, 1'b0, 1'b1);
    for (int c = 0; c < 32; c++) step(1, 0, 32'h0, 8'h00, 8'hFF, 0);

    // Randomized traffic: mostly enabled, sparse loads, zero-heavy nibbles.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] dd;
      for (int k = 0; k < 8; k++) dd[k*4 +: 4] = ($urandom_range(1, 0) == 0) ? 4'h0 : 4'($urandom);
      step(($urandom_range(40, 0) != 0), ($urandom_range(15, 0) == 0), dd,
           ($urandom_range(3, 0) == 0) ? 8'($urandom) : 8'h00,
           ($urandom_range(3, 0) == 0) ? 8'($urandom) : 8'hFF,
           1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scanner for the 8-digit seven-segment display. It takes eight hex nibbles, a decimal-point mask and a blanking mask, and decodes one digit at a time. It rotates through the digits at a fixed scan rate and presents each frame word as data[15:0] = {sel[7:0], seg[7:0]}. It sits directly upstream of the 74HC595 serial driver, which consumes data and en unchanged.

## Interface
- SCAN_DIV, 50000: clk_50mhz cycles per digit slot (1 ms at 50 MHz); legal range 2..2^20.
- SEG_ACTIVE_LOW, 1: 1 = segment/dp lines driven low to light.
- SEL_ACTIVE_LOW, 1: 1 = the selected digit line is 0 and all others are 1.
- clk_50mhz  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  scan enable; 0 blanks the display and holds the scan.
- disp_data  in  32  eight hex nibbles; [3:0] = digit 0 (rightmost), [31:28] = digit 7.
- dp_mask  in  8  bit i lights the decimal point of digit i.
- digit_en  in  8  bit i = 0 forces digit i dark (segments and dp off, sel still rotates).
- lz_en  in  1  leading-zero suppression enable.
- load  in  1  one-cycle strobe to capture disp_data, dp_mask, digit_en and lz_en.
- data  out  16  {sel, seg} to the serial driver, registered.
- drv_en  out  1  registered copy of en, for the serial driver's en.
- frame_start  out  1  one-cycle pulse when digit 0 becomes active.

## Operation
- Shadow registers hold the committed display set: data, dp, digit_en and lz. All display output comes from the shadow set, never from the live inputs.
- A load strobe captures the inputs into a pending set and sets pend.
  - The pending set commits to the shadow set at the next frame boundary (digit index wraps 7->0), or immediately if en=0. This prevents tearing.
  - A load in the same cycle as a commit captures and commits that cycle's inputs directly and leaves pend clear.
  - A second load before commit overwrites the pending set.
- Scan state machine, two states:
  - IDLE (en=0): divider = 0, digit index = 0, data = OFF word.
  - SCAN (en=1): the divider counts 0..SCAN_DIV-1. At terminal count the index advances 0→1→…→7→0.
  - An en falling edge in any cycle returns to IDLE on the next clock. An en rising edge starts at digit 0 with frame_start.
- Leading-zero suppression (lz=1):
  - Scanning from digit 7 downward, each digit is blanked while its nibble is 0 and every digit above it is also blanked.
  - Digit 0 is never blanked by suppression.
  - A dp bit set on a digit stops suppression at that digit.
- Decoder output is active-high {dp, g, f, e, d, c, b, a}: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71; dp adds 0x80.
  - SEG_ACTIVE_LOW inverts the full byte.
  - A blanked digit outputs the segment-off byte.
- sel is one-hot on bit index, inverted when SEL_ACTIVE_LOW=1.
- The OFF word is all sel lines inactive and all segments off. With default parameters OFF = 16'hFFFF.

## Timing
- Reset values: data = OFF word, drv_en = 0, frame_start = 0, divider = 0, index = 0, pend = 0, shadow data = 0, shadow dp = 0, shadow digit_en = 8'hFF, shadow lz = 0.
- data updates exactly 1 cycle after an index change or commit. It is stable for the remaining SCAN_DIV-1 cycles of the slot.
- Frame period is 8*SCAN_DIV cycles.
- frame_start is high in the same cycle that data first shows digit 0.
- drv_en has 1-cycle latency from en.
- en=0 to OFF word on data takes 1 cycle.
- The slot is much longer than the serial driver's 32-edge shift frame (2.56 µs), so data is sampled stable by the driver.
- Divider width is ceil(log2(SCAN_DIV)). The divider wraps only at SCAN_DIV-1, never at power-of-two.

## Structure
- Shared package seg_pkg holds:
  - the 16-entry hex-to-segment constant table;
  - SEG_OFF_AH = 8'h00;
  - the DIGITS = 8 constant;
  - the IDLE/SCAN state encoding.
- Sub-module hex_to_seg7 is purely combinational: nibble, dp and blank in, 8-bit active-high segment byte out.
- The scanner, shadow/pending logic and suppression stay in seg_scan_ctrl.

## Test plan
Bench uses SCAN_DIV=4 and default polarities.
- **Reset and blank**: hold rst_n low, then release with en=0 → data = 16'hFFFF, drv_en = 0, frame_start never pulses.
- **Basic scan**: load disp_data = 32'h76543210, dp_mask = 0, digit_en = 8'hFF, lz_en = 0, then raise en.
  - Digit 0 shows data = 16'hFE_C0 with frame_start.
  - After 4 cycles data = 16'hFD_F9.
  - Digit 7 shows 16'h7F_F8.
  - Frame repeats every 32 cycles.
- **Tear-free load**: during digit 3, load 32'hFFFFFFFF → digits 3..7 of the current frame keep the old values; the next frame starts with seg = 8'h8E (F).
- **Leading zeros**: load 32'h00000500 with lz_en = 1 → digits 3..7 show seg = 8'hFF; digit 2 shows 8'h92; digits 1 and 0 show 8'hC0. Repeat with dp_mask = 8'h10 → digit 4 shows 8'h40 and digit 3 shows 8'hC0.
- **Mid-scan disable**: drop en during digit 5 → next cycle data = 16'hFFFF. Re-raise en → restarts at digit 0 with frame_start; a load issued while disabled is visible at once.
- **Reset mid-operation**: assert rst_n during digit 6 with pend set → data = 16'hFFFF asynchronously, pending load discarded, shadow returns to reset values.
